// File: rtl/ctrl_input_conditioner.sv
// Synchronizes and debounces a raw 1-bit control input into a clean level with
// single-cycle rise/fall strobes and a saturating count of rejected transitions.
module ctrl_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int CNT_W           = 16,
  parameter int GLITCH_W        = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                raw_in,
  input  logic                glitch_clr,
  output logic                a_out,
  output logic                rise,
  output logic                fall,
  output logic [GLITCH_W-1:0] glitch_count
);

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    CHK_HIGH    = 2'd1,
    STABLE_HIGH = 2'd2,
    CHK_LOW     = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0]    LP_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]    LP_ONE  = CNT_W'(1);
  localparam logic [GLITCH_W-1:0] LP_GMAX = '1;

  logic                r_sync1;
  logic                r_s;
  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_a;
  logic                r_rise;
  logic                r_fall;
  logic [GLITCH_W-1:0] r_glitch;
  logic                w_abort;

  // Two-flop synchronizer; only r_s is consumed below.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b0;
      r_s     <= 1'b0;
    end else begin
      r_sync1 <= raw_in;
      r_s     <= r_sync1;
    end
  end

  assign w_abort = ((r_state == CHK_HIGH) && !r_s) || ((r_state == CHK_LOW) && r_s);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= STABLE_LOW;
      r_cnt   <= '0;
      r_a     <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      case (r_state)
        STABLE_LOW: begin
          if (r_s) begin
            r_state <= CHK_HIGH;
            r_cnt   <= LP_ONE;
          end
        end
        CHK_HIGH: begin
          if (!r_s) begin
            r_state <= STABLE_LOW;
          end else if (r_cnt == LP_LAST) begin
            r_state <= STABLE_HIGH;
            r_a     <= 1'b1;
            r_rise  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + LP_ONE;
          end
        end
        STABLE_HIGH: begin
          if (!r_s) begin
            r_state <= CHK_LOW;
            r_cnt   <= LP_ONE;
          end
        end
        CHK_LOW: begin
          if (r_s) begin
            r_state <= STABLE_HIGH;
          end else if (r_cnt == LP_LAST) begin
            r_state <= STABLE_LOW;
            r_a     <= 1'b0;
            r_fall  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + LP_ONE;
          end
        end
        default: r_state <= STABLE_LOW;
      endcase
    end
  end

  // Clear takes priority over a coincident abort; count holds at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_glitch <= '0;
    end else if (glitch_clr) begin
      r_glitch <= '0;
    end else if (w_abort && (r_glitch != LP_GMAX)) begin
      r_glitch <= r_glitch + GLITCH_W'(1);
    end
  end

  assign a_out        = r_a;
  assign rise         = r_rise;
  assign fall         = r_fall;
  assign glitch_count = r_glitch;

endmodule

// File: tb/tb_ctrl_input_conditioner.sv
// Directed bench: expected strobe events are queued when stimulus is driven and
// compared when the DUT strobes; levels and counters are asserted inline.
module tb_ctrl_input_conditioner;
  localparam int D  = 4;
  localparam int GW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          raw_in = 1'b1;
  logic          glitch_clr = 1'b0;
  logic          a_out, rise, fall;
  logic [GW-1:0] glitch_count;

  ctrl_input_conditioner #(.DEBOUNCE_CYCLES(D), .CNT_W(4), .GLITCH_W(GW)) dut (
    .clk(clk), .reset(reset), .raw_in(raw_in), .glitch_clr(glitch_clr),
    .a_out(a_out), .rise(rise), .fall(fall), .glitch_count(glitch_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { bit is_rise; int at; } ev_t;
  ev_t sbq[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called just after a negedge: the new level is first sampled at edge cyc+1.
  task automatic drive(input logic v, input bit expect_strobe);
    raw_in = v;
    if (expect_strobe) sbq.push_back('{is_rise: v, at: cyc + 2 + D});
  endtask

  // Scoreboard: every strobe must match the next queued event.
  always @(negedge clk) begin
    ev_t e;
    if (rise || fall) begin
      if (sbq.size() == 0) begin
        chk("unexpected_strobe", {30'd0, rise, fall}, 32'd0);
      end else begin
        e = sbq.pop_front();
        chk(e.is_rise ? "rise_cycle" : "fall_cycle", cyc, e.at);
        chk("strobe_kind", {30'd0, rise, fall}, e.is_rise ? 32'd2 : 32'd1);
        chk("a_out_at_strobe", {31'd0, a_out}, {31'd0, e.is_rise});
      end
    end
  end

  // Simple idle/start/stop controller driven by a_out.
  typedef enum logic [1:0] {F_IDLE, F_START, F_STOP} fst_t;
  fst_t fst = F_IDLE;
  bit   fsm_en = 1'b0;
  int   n_start = 0, n_stop = 0, n_idle = 0, z_cyc = 0;
  logic z;
  assign z = (fst == F_START);

  always @(posedge clk) begin
    case (fst)
      F_IDLE:  if (a_out)  begin fst <= F_START; if (fsm_en) n_start++; end
      F_START: if (!a_out) begin fst <= F_STOP;  if (fsm_en) n_stop++;  end
      default: begin fst <= F_IDLE; if (fsm_en) n_idle++; end
    endcase
  end

  always @(negedge clk) if (fsm_en && z) z_cyc++;

  initial begin
    int k1, k2;

    // Reset held with raw_in high: everything stays at zero.
    repeat (10) begin
      @(negedge clk);
      chk("reset_hold", {27'd0, a_out, rise, fall, glitch_count}, 32'd0);
    end
    reset = 1'b1;
    sbq.push_back('{is_rise: 1'b1, at: cyc + D + 2});
    step(D + 1);
    chk("post_reset_not_yet", {31'd0, a_out}, 32'd0);
    step(2);
    chk("post_reset_a", {31'd0, a_out}, 32'd1);

    // Clean edges.
    drive(1'b0, 1'b1);
    step(D + 4);
    chk("clean_low", {31'd0, a_out}, 32'd0);
    drive(1'b1, 1'b1);
    step(D + 2);
    chk("clean_rise_level", {30'd0, a_out, rise}, 32'd3);
    step(1);
    chk("clean_rise_drop", {30'd0, a_out, rise}, 32'd2);
    step(4);
    drive(1'b0, 1'b1);
    step(D + 4);
    chk("clean_fall_level", {30'd0, a_out, fall}, 32'd0);

    // Bounce: two short pulses rejected, then a stable high accepted.
    raw_in = 1'b1; step(3);
    raw_in = 1'b0; step(2);
    raw_in = 1'b1; step(3);
    raw_in = 1'b0; step(2);
    chk("bounce_held_low", {31'd0, a_out}, 32'd0);
    drive(1'b1, 1'b1);
    step(D + 4);
    chk("bounce_glitches", glitch_count, 32'd2);
    chk("bounce_a", {31'd0, a_out}, 32'd1);
    drive(1'b0, 1'b1);
    step(D + 4);

    // Saturation and clear-vs-abort priority.
    glitch_clr = 1'b1; step(1); glitch_clr = 1'b0;
    chk("glitch_clr", glitch_count, 32'd0);
    for (int i = 1; i <= 5; i++) begin
      raw_in = 1'b1; step(3);
      raw_in = 1'b0; step(4);
      chk("glitch_sat", glitch_count, (i < 3) ? i : 3);
    end
    raw_in = 1'b1; step(3);
    raw_in = 1'b0; step(2);
    glitch_clr = 1'b1; step(1); glitch_clr = 1'b0;
    chk("clr_wins", glitch_count, 32'd0);
    step(3);
    chk("clr_wins_hold", glitch_count, 32'd0);
    chk("sat_a_low", {31'd0, a_out}, 32'd0);

    // Reset asserted two cycles into CHK_HIGH.
    drive(1'b1, 1'b0);
    step(4);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("midchk_reset", {27'd0, a_out, rise, fall, glitch_count}, 32'd0);
    end
    reset = 1'b1;
    sbq.push_back('{is_rise: 1'b1, at: cyc + D + 2});
    step(D + 1);
    chk("midchk_restart_wait", {31'd0, a_out}, 32'd0);
    step(2);
    chk("midchk_restart_a", {31'd0, a_out}, 32'd1);
    drive(1'b0, 1'b1);
    step(D + 4);

    // Integration with the controller: bouncy press then bouncy release.
    fsm_en = 1'b1;
    raw_in = 1'b1; step(1); raw_in = 1'b0; step(1);
    raw_in = 1'b1; step(1); raw_in = 1'b0; step(1);
    k1 = cyc;
    drive(1'b1, 1'b1);
    step(12);
    raw_in = 1'b0; step(1); raw_in = 1'b1; step(1);
    raw_in = 1'b0; step(1); raw_in = 1'b1; step(1);
    k2 = cyc;
    drive(1'b0, 1'b1);
    step(D + 6);
    fsm_en = 1'b0;
    chk("fsm_start_visits", n_start, 32'd1);
    chk("fsm_stop_visits", n_stop, 32'd1);
    chk("fsm_idle_returns", n_idle, 32'd1);
    chk("fsm_z_cycles", z_cyc, k2 - k1);
    chk("fsm_final_idle", {30'd0, fst}, {30'd0, F_IDLE});

    chk("scoreboard_empty", sbq.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
